write_back_buffer: RTL and testbench

//  Multi-entry coalescing write-back buffer between the L2 cache (Wishbone slave side) and physical memory (master side).

---
 rtl/write_back_buffer_pkg.sv | 35 +++
 rtl/write_back_buffer_if.sv | 17 +
 rtl/write_back_buffer_match.sv | 32 +++
 rtl/write_back_buffer.sv | 142 ++++++++++++++
 tb/tb_write_back_buffer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/write_back_buffer_pkg.sv
// Shared types and sizing for the write-back buffer.
//   LINE_W : line width in bits
//   ADR_W  : line address width
//   DEPTH  : number of buffered lines (power of 2, >= 2)
//   wbb_entry_t : one buffered dirty line
//   wbb_state_t : controller states
package write_back_buffer_pkg;

   localparam int LINE_W = 128;
   localparam int ADR_W  = 12;
   localparam int DEPTH  = 4;
   localparam int SEL_W  = LINE_W / 8;
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);

   typedef struct packed {
      logic              valid;
      logic [ADR_W-1:0]  adr;
      logic [LINE_W-1:0] data;
   } wbb_entry_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HIT,
      S_FWD,
      S_DRAIN,
      S_GAP
   } wbb_state_t;

   // DEPTH is a power of 2, so the natural wrap of IDX_W bits is mod DEPTH.
   function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
      return p + IDX_W'(1);
   endfunction

endpackage

// File: rtl/write_back_buffer_if.sv
// Line-wide Wishbone-style bus used on both sides of the buffer.
//   master drives cyc/stb/we/adr/dat_m, slave drives dat_s/ack.
interface write_back_buffer_if;
   import write_back_buffer_pkg::*;

   logic              cyc;
   logic              stb;
   logic              we;
   logic [ADR_W-1:0]  adr;
   logic [LINE_W-1:0] dat_m;
   logic [LINE_W-1:0] dat_s;
   logic              ack;

   modport master (output cyc, stb, we, adr, dat_m, input  dat_s, ack);
   modport slave  (input  cyc, stb, we, adr, dat_m, output dat_s, ack);

endinterface

// File: rtl/write_back_buffer_match.sv
// Combinational DEPTH-way address compare against the buffered lines.
//   i_valid   : per-entry valid bits
//   i_adrs    : per-entry line addresses
//   i_adr     : address to look up
//   o_hit     : some valid entry holds i_adr
//   o_hit_idx : index of that entry (coalescing keeps it unique)
module wbb_match
   import write_back_buffer_pkg::*;
(
   input  logic [DEPTH-1:0]            i_valid,
   input  logic [DEPTH-1:0][ADR_W-1:0] i_adrs,
   input  logic [ADR_W-1:0]            i_adr,
   output logic                        o_hit,
   output logic [IDX_W-1:0]            o_hit_idx
);

   logic [DEPTH-1:0] w_onehot;

   for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
      assign w_onehot[g] = i_valid[g] && (i_adrs[g] == i_adr);
   end

   assign o_hit = |w_onehot;

   // At most one bit is set, so OR-ing indices yields the encoded index.
   always_comb begin
      o_hit_idx = '0;
      for (int i = 0; i < DEPTH; i++)
         if (w_onehot[i]) o_hit_idx = o_hit_idx | IDX_W'(i);
   end

endmodule

// File: rtl/write_back_buffer.sv
// Coalescing write-back buffer between L2 (slave side) and pmem (master side).
//   i_clk, i_rst  : clock, async active-high reset
//   io_l2         : L2 requests (write = eviction, read = line fetch)
//   io_mem        : pmem bus (reads forwarded, queued lines drained)
//   o_mem_sel     : pmem byte enables, always all ones
//   i_flush       : drain everything and hold off new L2 writes
//   o_flush_done  : flush requested and buffer empty
//   o_count       : number of queued lines
module write_back_buffer
   import write_back_buffer_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   write_back_buffer_if.slave  io_l2,
   write_back_buffer_if.master io_mem,
   output logic [SEL_W-1:0]    o_mem_sel,
   input  logic                i_flush,
   output logic                o_flush_done,
   output logic [CNT_W-1:0]    o_count
);

   wbb_entry_t        r_ent [DEPTH];
   logic [IDX_W-1:0]  r_head, r_tail;
   logic [CNT_W-1:0]  r_count;
   wbb_state_t        r_state;
   logic              r_l2_ack;
   logic [LINE_W-1:0] r_l2_dat_s;
   logic              r_mem_cyc, r_mem_we;
   logic [ADR_W-1:0]  r_mem_adr;
   logic [LINE_W-1:0] r_mem_dat_m;

   logic [DEPTH-1:0]            w_valid;
   logic [DEPTH-1:0][ADR_W-1:0] w_adrs;
   logic                        w_hit, w_req, w_full, w_empty, w_wr_ok;
   logic [IDX_W-1:0]            w_hit_idx;

   for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign w_valid[g] = r_ent[g].valid;
      assign w_adrs[g]  = r_ent[g].adr;
   end

   wbb_match u_match (
      .i_valid   (w_valid),
      .i_adrs    (w_adrs),
      .i_adr     (io_l2.adr),
      .o_hit     (w_hit),
      .o_hit_idx (w_hit_idx)
   );

   assign w_req   = io_l2.cyc && io_l2.stb;
   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);
   // A coalescing write needs no free slot; flush blocks every write.
   assign w_wr_ok = !i_flush && (w_hit || !w_full);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_state     <= S_IDLE;
         r_l2_ack    <= 1'b0;
         r_l2_dat_s  <= '0;
         r_mem_cyc   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_adr   <= '0;
         r_mem_dat_m <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req && !io_l2.we) begin
                  if (w_hit) begin
                     r_l2_dat_s <= r_ent[w_hit_idx].data;
                     r_l2_ack   <= 1'b1;
                     r_state    <= S_HIT;
                  end else begin
                     // Read misses go ahead of queued drains.
                     r_mem_cyc <= 1'b1;
                     r_mem_we  <= 1'b0;
                     r_mem_adr <= io_l2.adr;
                     r_state   <= S_FWD;
                  end
               end else if (w_req && w_wr_ok) begin
                  if (w_hit) begin
                     r_ent[w_hit_idx].data <= io_l2.dat_m;
                  end else begin
                     r_ent[r_tail] <= '{valid: 1'b1, adr: io_l2.adr, data: io_l2.dat_m};
                     r_tail        <= ptr_inc(r_tail);
                     r_count       <= r_count + CNT_W'(1);
                  end
                  r_l2_ack <= 1'b1;
                  r_state  <= S_HIT;
               end else if (!w_empty) begin
                  // Idle bus, blocked write (full/flush) or flush: drain head.
                  r_mem_cyc   <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_mem_adr   <= r_ent[r_head].adr;
                  r_mem_dat_m <= r_ent[r_head].data;
                  r_state     <= S_DRAIN;
               end
            end
            S_HIT: begin
               r_l2_ack <= 1'b0;
               r_state  <= S_GAP;
            end
            S_FWD: begin
               if (io_mem.ack) begin
                  r_mem_cyc  <= 1'b0;
                  r_l2_dat_s <= io_mem.dat_s;
                  r_l2_ack   <= 1'b1;
                  r_state    <= S_HIT;
               end
            end
            S_DRAIN: begin
               if (io_mem.ack) begin
                  r_mem_cyc           <= 1'b0;
                  r_mem_we            <= 1'b0;
                  r_ent[r_head].valid <= 1'b0;
                  r_head              <= ptr_inc(r_head);
                  r_count             <= r_count - CNT_W'(1);
                  r_state             <= S_GAP;
               end
            end
            S_GAP:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign io_l2.ack    = r_l2_ack;
   assign io_l2.dat_s  = r_l2_dat_s;
   assign io_mem.cyc   = r_mem_cyc;
   assign io_mem.stb   = r_mem_cyc;
   assign io_mem.we    = r_mem_we;
   assign io_mem.adr   = r_mem_adr;
   assign io_mem.dat_m = r_mem_dat_m;
   assign o_mem_sel    = '1;
   assign o_flush_done = i_flush && w_empty;
   assign o_count      = r_count;

endmodule

// File: tb/tb_write_back_buffer.sv
module tb_write_back_buffer;
   import write_back_buffer_pkg::*;

   logic              clk, rst, flush, flush_done, mem_go;
   logic [SEL_W-1:0]  mem_sel;
   logic [CNT_W-1:0]  count;
   int                n_tests, n_fail, rd_cnt;
   logic [ADR_W-1:0]  wr_adr_q[$];
   logic [LINE_W-1:0] wr_dat_q[$];

   write_back_buffer_if l2();
   write_back_buffer_if mem();

   write_back_buffer dut (
      .i_clk(clk), .i_rst(rst), .io_l2(l2), .io_mem(mem),
      .o_mem_sel(mem_sel), .i_flush(flush), .o_flush_done(flush_done), .o_count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [LINE_W-1:0] pat(input logic [ADR_W-1:0] a);
      return {8{4'hC, a}};
   endfunction

   function automatic logic [LINE_W-1:0] dv(input int n);
      return {4{32'hDA7A_0000 + 32'(n)}};
   endfunction

   // pmem model: one-cycle ack when allowed, logs writes, returns pat() on reads
   initial begin
      mem.ack = 1'b0;
      mem.dat_s = '0;
      forever begin
         @(negedge clk);
         if (rst) mem.ack = 1'b0;
         else if (mem.ack) mem.ack = 1'b0;
         else if (mem.cyc && mem.stb && mem_go) begin
            mem.ack = 1'b1;
            if (mem.we) begin
               wr_adr_q.push_back(mem.adr);
               wr_dat_q.push_back(mem.dat_m);
            end else begin
               mem.dat_s = pat(mem.adr);
               rd_cnt++;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One L2 transaction, started at a negedge; lat = negedges until ack seen.
   task automatic l2_xfer(input logic we, input logic [ADR_W-1:0] adr, input logic [LINE_W-1:0] dat,
                          output logic [LINE_W-1:0] rdata, output int lat);
      l2.cyc = 1'b1; l2.stb = 1'b1; l2.we = we; l2.adr = adr; l2.dat_m = dat;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!l2.ack && lat < 100);
      rdata = l2.dat_s;
      l2.cyc = 1'b0; l2.stb = 1'b0; l2.we = 1'b0;
   endtask

   task automatic wait_empty();
      int k = 0;
      while (count != 0 && k < 200) begin @(negedge clk); k++; end
      chk("drain_to_empty_in_time", 128'(k < 200), 128'(1));
   endtask

   typedef struct {
      logic              we;
      logic [ADR_W-1:0]  adr;
      logic [LINE_W-1:0] dat;
      int                exp_lat;
      int                exp_cnt;
      logic [LINE_W-1:0] exp_rd;
      int                exp_rdcnt;
   } vec_t;

   vec_t              vt[10];
   logic [LINE_W-1:0] rd;
   int                lat, base, acks;
   logic [ADR_W-1:0]  exp_adr[5];
   logic [LINE_W-1:0] exp_dat[5];

   initial begin
      // back-to-back after reset; pmem always responsive, L2 never idle
      vt[0] = '{1'b1, 12'h010, dv(0), 1, 1, '0, 0};
      vt[1] = '{1'b1, 12'h010, dv(1), 3, 1, '0, 0};
      vt[2] = '{1'b1, 12'h020, dv(2), 3, 2, '0, 0};
      vt[3] = '{1'b0, 12'h020, '0,    3, 2, dv(2), 0};
      vt[4] = '{1'b0, 12'h010, '0,    3, 2, dv(1), 0};
      vt[5] = '{1'b0, 12'h070, '0,    4, 2, pat(12'h070), 1};
      vt[6] = '{1'b1, 12'h030, dv(3), 3, 3, '0, 1};
      vt[7] = '{1'b1, 12'h040, dv(4), 3, 4, '0, 1};
      vt[8] = '{1'b1, 12'h040, dv(5), 3, 4, '0, 1};
      vt[9] = '{1'b0, 12'h040, '0,    3, 4, dv(5), 1};
      exp_adr = '{12'h010, 12'h020, 12'h030, 12'h040, 12'h050};
      exp_dat = '{dv(1), dv(2), dv(3), dv(5), dv(6)};

      n_tests = 0; n_fail = 0; rd_cnt = 0;
      rst = 1'b1; flush = 1'b0; mem_go = 1'b1;
      l2.cyc = 1'b0; l2.stb = 1'b0; l2.we = 1'b0; l2.adr = '0; l2.dat_m = '0;
      idle(2);
      chk("rst_l2_ack", 128'(l2.ack), 128'(0));
      chk("rst_mem_cyc", 128'(mem.cyc), 128'(0));
      chk("rst_count", 128'(count), 128'(0));
      chk("rst_flush_done", 128'(flush_done), 128'(0));
      chk("rst_l2_dat_s", l2.dat_s, '0);
      chk("mem_sel_ones", 128'(mem_sel), 128'(16'hFFFF));
      rst = 1'b0;
      idle(2);

      for (int i = 0; i < 10; i++) begin
         l2_xfer(vt[i].we, vt[i].adr, vt[i].dat, rd, lat);
         chk($sformatf("v%0d_latency", i), 128'(lat), 128'(vt[i].exp_lat));
         chk($sformatf("v%0d_count", i), 128'(count), 128'(vt[i].exp_cnt));
         chk($sformatf("v%0d_pmem_reads", i), 128'(rd_cnt), 128'(vt[i].exp_rdcnt));
         if (!vt[i].we) chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
      end
      chk("no_drain_while_busy", 128'(wr_adr_q.size()), 128'(0));

      // 5th distinct write on a full buffer waits for one head drain
      l2_xfer(1'b1, 12'h050, dv(6), rd, lat);
      chk("full_write_latency", 128'(lat), 128'(6));
      chk("full_write_count", 128'(count), 128'(4));
      chk("full_write_one_drain", 128'(wr_adr_q.size()), 128'(1));
      wait_empty();
      chk("drain_total", 128'(wr_adr_q.size()), 128'(5));
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("drain%0d_adr", i), 128'((i < wr_adr_q.size()) ? wr_adr_q[i] : 12'hFFF), 128'(exp_adr[i]));
         chk($sformatf("drain%0d_dat", i), (i < wr_dat_q.size()) ? wr_dat_q[i] : '0, exp_dat[i]);
      end

      // read miss beats pending drains
      idle(3);
      l2_xfer(1'b1, 12'h080, dv(7), rd, lat);
      chk("idle_write_latency", 128'(lat), 128'(1));
      l2_xfer(1'b1, 12'h090, dv(8), rd, lat);
      base = rd_cnt;
      l2_xfer(1'b0, 12'h070, '0, rd, lat);
      chk("miss_latency", 128'(lat), 128'(4));
      chk("miss_rdata", rd, pat(12'h070));
      chk("miss_pmem_read", 128'(rd_cnt - base), 128'(1));
      chk("miss_before_drain", 128'(wr_adr_q.size()), 128'(5));
      wait_empty();
      chk("miss_then_drain", 128'(wr_adr_q.size()), 128'(7));

      // flush with pmem stalled mid-drain
      idle(3);
      mem_go = 1'b0;
      l2_xfer(1'b1, 12'h0A0, dv(9), rd, lat);
      l2_xfer(1'b1, 12'h0B0, dv(10), rd, lat);
      idle(4);
      chk("stall_drain_cyc", 128'(mem.cyc), 128'(1));
      chk("stall_drain_adr", 128'(mem.adr), 128'(12'h0A0));
      flush = 1'b1;
      #1 chk("flush_not_done", 128'(flush_done), 128'(0));
      mem_go = 1'b1;
      base = 0;
      while (!flush_done && base < 50) begin @(negedge clk); base++; end
      chk("flush_done", 128'(flush_done), 128'(1));
      chk("flush_count", 128'(count), 128'(0));
      chk("flush_drained", 128'(wr_adr_q.size()), 128'(9));
      l2.cyc = 1'b1; l2.stb = 1'b1; l2.we = 1'b1; l2.adr = 12'h0C0; l2.dat_m = dv(11);
      acks = 0;
      repeat (8) begin @(negedge clk); if (l2.ack) acks++; end
      chk("flush_blocks_write", 128'(acks), 128'(0));
      flush = 1'b0;
      base = 0;
      while (!l2.ack && base < 50) begin @(negedge clk); base++; end
      chk("write_after_flush_ack", 128'(l2.ack), 128'(1));
      chk("write_after_flush_count", 128'(count), 128'(1));
      l2.cyc = 1'b0; l2.stb = 1'b0; l2.we = 1'b0;
      wait_empty();
      chk("flush_write_drained", 128'((wr_adr_q.size() == 10) ? wr_adr_q[9] : 12'hFFF), 128'(12'h0C0));

      // async reset while draining discards queued lines
      idle(3);
      mem_go = 1'b0;
      l2_xfer(1'b1, 12'h0D0, dv(12), rd, lat);
      l2_xfer(1'b1, 12'h0E0, dv(13), rd, lat);
      l2_xfer(1'b1, 12'h0F0, dv(14), rd, lat);
      chk("pre_reset_count", 128'(count), 128'(3));
      idle(4);
      chk("pre_reset_cyc", 128'(mem.cyc), 128'(1));
      rst = 1'b1;
      #1;
      chk("reset_drops_cyc", 128'(mem.cyc), 128'(0));
      chk("reset_count", 128'(count), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      mem_go = 1'b1;
      idle(2);
      base = rd_cnt;
      l2_xfer(1'b0, 12'h0E0, '0, rd, lat);
      chk("post_reset_read_latency", 128'(lat), 128'(2));
      chk("post_reset_read_pmem", 128'(rd_cnt - base), 128'(1));
      chk("post_reset_rdata", rd, pat(12'h0E0));
      idle(5);
      chk("post_reset_no_drain", 128'(wr_adr_q.size()), 128'(10));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
